// File: rtl/alu_mdu_unit_pkg.sv
// Shared constants for the ALU/MDU execution unit: opcodes, FSM states, helpers.
package alu_mdu_unit_pkg;

  localparam int unsigned OPC_W = 5;

  typedef logic [OPC_W-1:0] opc_t;

  localparam opc_t OP_ADD    = 5'd0;
  localparam opc_t OP_SUB    = 5'd1;
  localparam opc_t OP_AND    = 5'd2;
  localparam opc_t OP_OR     = 5'd3;
  localparam opc_t OP_XOR    = 5'd4;
  localparam opc_t OP_SLL    = 5'd5;
  localparam opc_t OP_SRL    = 5'd6;
  localparam opc_t OP_SRA    = 5'd7;
  localparam opc_t OP_SLT    = 5'd8;
  localparam opc_t OP_SLTU   = 5'd9;
  localparam opc_t OP_EQ     = 5'd10;
  localparam opc_t OP_NE     = 5'd11;
  localparam opc_t OP_GEU    = 5'd12;
  localparam opc_t OP_GE     = 5'd13;
  localparam opc_t OP_MUL    = 5'd16;
  localparam opc_t OP_MULH   = 5'd17;
  localparam opc_t OP_MULHSU = 5'd18;
  localparam opc_t OP_MULHU  = 5'd19;
  localparam opc_t OP_DIV    = 5'd20;
  localparam opc_t OP_DIVU   = 5'd21;
  localparam opc_t OP_REM    = 5'd22;
  localparam opc_t OP_REMU   = 5'd23;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

  // Low three opcode bits of the M-extension group.
  typedef enum logic [2:0] {
    MF_MUL    = 3'd0,
    MF_MULH   = 3'd1,
    MF_MULHSU = 3'd2,
    MF_MULHU  = 3'd3,
    MF_DIV    = 3'd4,
    MF_DIVU   = 3'd5,
    MF_REM    = 3'd6,
    MF_REMU   = 3'd7
  } mdu_fn_e;

  // op[4] marks the M group; codes 24-31 are undefined and fall back to ADD.
  function automatic logic is_muldiv(input opc_t op);
    return op[4] & ~op[3];
  endfunction

endpackage

// File: rtl/alu_mdu_unit_if.sv
// Issue-side and result-side handshake bundle of the execution unit.
interface alu_mdu_unit_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned OP_W  = 5
) ();

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_op;
  logic [XLEN-1:0]  in_lv;
  logic [XLEN-1:0]  in_rv;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;

  // Reservation station / CDB side.
  modport master (
    output in_valid, in_op, in_lv, in_rv, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  // Execution unit side.
  modport slave (
    input  in_valid, in_op, in_lv, in_rv, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );

endinterface

// File: rtl/alu_mdu_unit_muldiv_iter.sv
// Iterative multiply/divide: XLEN radix-2 steps on magnitudes, then one fix-up cycle.
module muldiv_iter
  import alu_mdu_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic            flush_i,
  input  logic            start_i,
  input  mdu_fn_e         fn_i,
  input  logic [XLEN-1:0] lv_i,
  input  logic [XLEN-1:0] rv_i,
  output mdu_state_e      state_o,
  output logic            done_c_o,
  output logic [XLEN-1:0] result_c_o
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam int unsigned PW    = 2 * XLEN;

  mdu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  mdu_fn_e          fn_q;
  logic             a_neg_q;
  logic             b_neg_q;
  logic             div0_q;
  logic [XLEN-1:0]  b_q;
  logic [PW-1:0]    p_q;

  logic             signed_a;
  logic             signed_b;
  logic             a_neg_d;
  logic             b_neg_d;
  logic [XLEN-1:0]  a_mag_d;
  logic [XLEN-1:0]  b_mag_d;

  logic [XLEN-1:0]  upper;
  logic [XLEN:0]    mul_sum;
  logic [XLEN:0]    rr;
  logic [XLEN:0]    diff;
  logic [PW-1:0]    step_d;

  logic [PW-1:0]    prod;
  logic [XLEN-1:0]  quo;
  logic [XLEN-1:0]  rem;

  // Operand signedness and magnitudes captured at start.
  always_comb begin
    signed_a = 1'b0;
    signed_b = 1'b0;
    case (fn_i)
      MF_MUL, MF_MULH, MF_DIV, MF_REM: begin
        signed_a = 1'b1;
        signed_b = 1'b1;
      end
      MF_MULHSU: signed_a = 1'b1;
      default: ;
    endcase
    a_neg_d = signed_a & lv_i[XLEN-1];
    b_neg_d = signed_b & rv_i[XLEN-1];
    a_mag_d = a_neg_d ? (~lv_i + XLEN'(1)) : lv_i;
    b_mag_d = b_neg_d ? (~rv_i + XLEN'(1)) : rv_i;
  end

  // One shift-add (multiply) or restoring-subtract (divide) step.
  // Partial remainder stays below the divisor, so diff[XLEN] is a clean borrow.
  always_comb begin
    upper   = p_q[PW-1:XLEN];
    mul_sum = {1'b0, upper} + (p_q[0] ? {1'b0, b_q} : '0);
    rr      = {upper, p_q[XLEN-1]};
    diff    = rr - {1'b0, b_q};
    if (fn_q >= MF_DIV) begin
      if (!diff[XLEN]) step_d = {diff[XLEN-1:0], p_q[XLEN-2:0], 1'b1};
      else             step_d = {rr[XLEN-1:0],   p_q[XLEN-2:0], 1'b0};
    end else begin
      step_d = {mul_sum, p_q[XLEN-1:1]};
    end
  end

  // Sign correction and result select in the FIX cycle.
  always_comb begin
    prod = (a_neg_q ^ b_neg_q) ? (~p_q + PW'(1)) : p_q;
    quo  = div0_q ? '1 :
           ((a_neg_q ^ b_neg_q) ? (~p_q[XLEN-1:0] + XLEN'(1)) : p_q[XLEN-1:0]);
    rem  = a_neg_q ? (~upper + XLEN'(1)) : upper;
    case (fn_q)
      MF_MUL:                       result_c_o = prod[XLEN-1:0];
      MF_MULH, MF_MULHSU, MF_MULHU: result_c_o = prod[PW-1:XLEN];
      MF_DIV, MF_DIVU:              result_c_o = quo;
      default:                      result_c_o = rem;
    endcase
  end

  assign done_c_o = (state_q == ST_FIX);
  assign state_o  = state_q;

  // Control FSM and datapath registers; frozen when en_i is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      fn_q    <= MF_MUL;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      div0_q  <= 1'b0;
      b_q     <= '0;
      p_q     <= '0;
    end else if (en_i) begin
      if (flush_i) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_i) begin
              state_q <= ST_BUSY;
              cnt_q   <= '0;
              fn_q    <= fn_i;
              a_neg_q <= a_neg_d;
              b_neg_q <= b_neg_d;
              div0_q  <= (rv_i == '0);
              b_q     <= b_mag_d;
              p_q     <= {XLEN'(0), a_mag_d};
            end
          end
          ST_BUSY: begin
            p_q   <= step_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(XLEN - 1)) state_q <= ST_FIX;
          end
          ST_FIX:  state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/alu_mdu_unit.sv
// Handshaked integer execution unit: single-cycle ALU ops plus iterative mul/div.
module alu_mdu_unit
  import alu_mdu_unit_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned OP_W  = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          flush,
  alu_mdu_unit_if.slave bus
);

  localparam int unsigned SH_W = $clog2(XLEN);

  logic [OP_W-1:0]  op;
  opc_t             op5;
  logic [XLEN-1:0]  lv;
  logic [XLEN-1:0]  rv;
  logic [SH_W-1:0]  shamt;

  mdu_state_e       mdu_state;
  logic             mdu_done_c;
  logic [XLEN-1:0]  mdu_result_c;

  logic             in_ready_c;
  logic             accept_c;
  logic             xfer_c;
  logic             start_c;
  logic [XLEN-1:0]  alu_c;

  logic             out_valid_q,  out_valid_d;
  logic [XLEN-1:0]  out_result_q, out_result_d;
  logic [TAG_W-1:0] out_tag_q,    out_tag_d;
  logic [TAG_W-1:0] mdu_tag_q,    mdu_tag_d;

  assign op    = bus.in_op;
  assign op5   = op[OPC_W-1:0];
  assign lv    = bus.in_lv;
  assign rv    = bus.in_rv;
  assign shamt = rv[SH_W-1:0];

  // Handshake qualifiers.
  assign in_ready_c = rdy & ~rst & (mdu_state == ST_IDLE) & (~out_valid_q | bus.out_ready);
  assign accept_c   = bus.in_valid & in_ready_c & ~flush;
  assign xfer_c     = out_valid_q & bus.out_ready & rdy;
  assign start_c    = accept_c & is_muldiv(op5);

  // Single-cycle ALU; unknown opcodes behave as ADD.
  always_comb begin
    alu_c = lv + rv;
    case (op5)
      OP_SUB:  alu_c = lv - rv;
      OP_AND:  alu_c = lv & rv;
      OP_OR:   alu_c = lv | rv;
      OP_XOR:  alu_c = lv ^ rv;
      OP_SLL:  alu_c = lv << shamt;
      OP_SRL:  alu_c = lv >> shamt;
      OP_SRA:  alu_c = XLEN'($signed(lv) >>> shamt);
      OP_SLT:  alu_c = XLEN'($signed(lv) < $signed(rv));
      OP_SLTU: alu_c = XLEN'(lv < rv);
      OP_EQ:   alu_c = XLEN'(lv == rv);
      OP_NE:   alu_c = XLEN'(lv != rv);
      OP_GEU:  alu_c = XLEN'(lv >= rv);
      OP_GE:   alu_c = XLEN'($signed(lv) >= $signed(rv));
      default: alu_c = lv + rv;
    endcase
  end

  muldiv_iter #(
    .XLEN(XLEN)
  ) u_muldiv (
    .clk       (clk),
    .rst       (rst),
    .en_i      (rdy),
    .flush_i   (flush),
    .start_i   (start_c),
    .fn_i      (mdu_fn_e'(op5[2:0])),
    .lv_i      (lv),
    .rv_i      (rv),
    .state_o   (mdu_state),
    .done_c_o  (mdu_done_c),
    .result_c_o(mdu_result_c)
  );

  // Result slot next state: flush beats load, load beats plain transfer.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
    mdu_tag_d    = mdu_tag_q;
    if (rdy) begin
      if (start_c) mdu_tag_d = bus.in_tag;
      if (flush) begin
        out_valid_d = 1'b0;
      end else if (accept_c && !is_muldiv(op5)) begin
        out_valid_d  = 1'b1;
        out_result_d = alu_c;
        out_tag_d    = bus.in_tag;
      end else if (mdu_done_c) begin
        out_valid_d  = 1'b1;
        out_result_d = mdu_result_c;
        out_tag_d    = mdu_tag_q;
      end else if (xfer_c) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Result slot registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
      mdu_tag_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
      mdu_tag_q    <= mdu_tag_d;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_tag    = out_tag_q;

endmodule

// File: tb/tb_alu_mdu_unit.sv
// Directed bench for alu_mdu_unit (XLEN=32).
module tb_alu_mdu_unit;
  import alu_mdu_unit_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned OP_W  = 5;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic flush;
  int   checks   = 0;
  int   failures = 0;

  alu_mdu_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W), .OP_W(OP_W)) bus ();

  alu_mdu_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .OP_W(OP_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .rdy  (rdy),
    .flush(flush),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input opc_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_lv    = a;
    bus.in_rv    = b;
    bus.in_tag   = tag;
  endtask

  task automatic run_simple(input opc_t op, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] tag, input logic [31:0] exp, input string name);
    bus.out_ready = 1'b1;
    drive(op, a, b, tag);
    #1;
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk({name, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({name, "_res"}, 64'(bus.out_result), 64'(exp));
    chk({name, "_tag"}, 64'(bus.out_tag), 64'(tag));
    tick();
  endtask

  task automatic run_mdu(input opc_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, input logic [31:0] exp, input int exp_lat,
                         input int pause_at, input string name);
    int  n;
    bit  rdy_seen;
    bus.out_ready = 1'b1;
    drive(op, a, b, tag);
    #1;
    tick();
    bus.in_valid = 1'b0;
    #1;
    n        = 1;
    rdy_seen = 1'b0;
    while (!bus.out_valid && n < 100) begin
      if (bus.in_ready) rdy_seen = 1'b1;
      if (pause_at != 0 && n == pause_at) begin
        rdy = 1'b0;
        repeat (3) begin
          tick();
          if (bus.in_ready) rdy_seen = 1'b1;
          n++;
        end
        rdy = 1'b1;
        #1;
      end
      tick();
      n++;
    end
    chk({name, "_lat"}, 64'(n), 64'(exp_lat));
    chk({name, "_res"}, 64'(bus.out_result), 64'(exp));
    chk({name, "_tag"}, 64'(bus.out_tag), 64'(tag));
    chk({name, "_busy_ready"}, 64'(rdy_seen), 64'd0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit stable;
    bit ir_bad;
    bit saw;

    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_lv = '0; bus.in_rv = '0;
    bus.in_tag = '0; bus.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_result", 64'(bus.out_result), 64'd0);
    chk("rst_tag", 64'(bus.out_tag), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // ADD wrap with back-to-back readiness
    bus.out_ready = 1'b1;
    drive(OP_ADD, 32'hFFFF_FFFF, 32'd1, 4'd3);
    #1;
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("add_valid", 64'(bus.out_valid), 64'd1);
    chk("add_res", 64'(bus.out_result), 64'd0);
    chk("add_tag", 64'(bus.out_tag), 64'd3);
    chk("add_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    chk("add_drained", 64'(bus.out_valid), 64'd0);

    run_simple(OP_SRA,  32'h8000_0000, 32'h24, 4'd1, 32'hF800_0000, "sra");
    run_simple(OP_SLT,  32'hFFFF_FFFF, 32'd1, 4'd2, 32'd1, "slt");
    run_simple(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 4'd4, 32'd0, "sltu");
    run_simple(OP_SUB,  32'd0, 32'd1, 4'd5, 32'hFFFF_FFFF, "sub");
    run_simple(OP_SLL,  32'd1, 32'd31, 4'd6, 32'h8000_0000, "sll");
    run_simple(OP_SRL,  32'h8000_0000, 32'd31, 4'd7, 32'd1, "srl");
    run_simple(OP_XOR,  32'h0000_F0F0, 32'h0000_FF00, 4'd8, 32'h0000_0FF0, "xor");
    run_simple(OP_AND,  32'h0000_F0F0, 32'h0000_FF00, 4'd9, 32'h0000_F000, "and");
    run_simple(OP_OR,   32'h0000_F0F0, 32'h0000_FF00, 4'd10, 32'h0000_FFF0, "or");
    run_simple(OP_GE,   32'hFFFF_FFFF, 32'd1, 4'd11, 32'd0, "ge");
    run_simple(OP_GEU,  32'hFFFF_FFFF, 32'd1, 4'd12, 32'd1, "geu");
    run_simple(OP_EQ,   32'd5, 32'd5, 4'd13, 32'd1, "eq");
    run_simple(OP_NE,   32'd5, 32'd5, 4'd14, 32'd0, "ne");
    run_simple(opc_t'(5'd24), 32'd2, 32'd3, 4'd15, 32'd5, "undef24");
    run_simple(opc_t'(5'd14), 32'd2, 32'd3, 4'd1, 32'd5, "undef14");

    // Multi-cycle ops, latency XLEN+2
    run_mdu(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 4'd3, 32'h8000_0000, 34, 0, "div_ovf");
    run_mdu(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 4'd4, 32'd0, 34, 0, "rem_ovf");
    run_mdu(OP_DIVU,   32'd7, 32'd0, 4'd5, 32'hFFFF_FFFF, 34, 0, "divu_z");
    run_mdu(OP_REMU,   32'd7, 32'd0, 4'd6, 32'd7, 34, 0, "remu_z");
    run_mdu(OP_DIV,    32'hFFFF_FFFB, 32'd0, 4'd7, 32'hFFFF_FFFF, 34, 0, "div_z");
    run_mdu(OP_REM,    32'hFFFF_FFFB, 32'd0, 4'd8, 32'hFFFF_FFFB, 34, 0, "rem_z");
    run_mdu(OP_DIV,    32'hFFFF_FFF9, 32'd2, 4'd9, 32'hFFFF_FFFD, 34, 0, "div_neg");
    run_mdu(OP_REM,    32'hFFFF_FFF9, 32'd2, 4'd10, 32'hFFFF_FFFF, 34, 0, "rem_neg");
    run_mdu(OP_DIVU,   32'd100, 32'd7, 4'd11, 32'd14, 34, 0, "divu");
    run_mdu(OP_REMU,   32'd100, 32'd7, 4'd12, 32'd2, 34, 0, "remu");
    run_mdu(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd13, 32'd0, 34, 0, "mulh");
    run_mdu(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd14, 32'hFFFF_FFFE, 34, 0, "mulhu");
    run_mdu(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd15, 32'hFFFF_FFFF, 34, 0, "mulhsu");
    run_mdu(OP_MULHU,  32'h8000_0000, 32'd4, 4'd2, 32'd2, 34, 0, "mulhu_pow");
    run_mdu(OP_MUL,    32'd123, 32'd456, 4'd1, 32'd56088, 34, 0, "mul");
    run_mdu(OP_MUL,    32'hFFFF_FFFD, 32'd7, 4'd6, 32'hFFFF_FFEB, 37, 10, "mul_stall");

    // Output back-pressure then transfer plus accept in one cycle
    bus.out_ready = 1'b0;
    drive(OP_ADD, 32'd5, 32'd6, 4'd9);
    #1;
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("hold_valid", 64'(bus.out_valid), 64'd1);
    chk("hold_res", 64'(bus.out_result), 64'd11);
    stable = 1'b1;
    ir_bad = 1'b0;
    repeat (5) begin
      tick();
      if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd11 || bus.out_tag !== 4'd9)
        stable = 1'b0;
      if (bus.in_ready !== 1'b0) ir_bad = 1'b1;
    end
    chk("hold_stable", 64'(stable), 64'd1);
    chk("hold_in_ready", 64'(ir_bad), 64'd0);
    bus.out_ready = 1'b1;
    drive(OP_SUB, 32'd10, 32'd3, 4'd2);
    #1;
    chk("b2b_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("b2b_valid", 64'(bus.out_valid), 64'd1);
    chk("b2b_res", 64'(bus.out_result), 64'd7);
    chk("b2b_tag", 64'(bus.out_tag), 64'd2);
    tick();
    chk("b2b_drained", 64'(bus.out_valid), 64'd0);

    // Flush at BUSY cycle 10 of a DIV
    drive(OP_DIV, 32'd100, 32'd7, 4'd5);
    #1;
    tick();
    bus.in_valid = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
    saw = 1'b0;
    repeat (40) begin
      tick();
      if (bus.out_valid) saw = 1'b1;
    end
    chk("flush_no_out", 64'(saw), 64'd0);

    // Flush and issue in the same cycle drops the op
    drive(OP_ADD, 32'd1, 32'd1, 4'd1);
    flush = 1'b1;
    #1;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("flush_drop_v0", 64'(bus.out_valid), 64'd0);
    tick();
    chk("flush_drop_v1", 64'(bus.out_valid), 64'd0);

    // Reset during BUSY aborts the op
    drive(OP_DIVU, 32'd100, 32'd3, 4'd4);
    #1;
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    chk("rst_busy_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_busy_idle", 64'(bus.in_ready), 64'd1);
    chk("rst_busy_valid", 64'(bus.out_valid), 64'd0);
    saw = 1'b0;
    repeat (40) begin
      tick();
      if (bus.out_valid) saw = 1'b1;
    end
    chk("rst_busy_no_out", 64'(saw), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
